// File: rtl/bullet_hit_receiver.sv
// Target-side bullet hit detection: overlap test, kill handshake back to the bullet,
// damage with an invulnerability window, and the death/respawn sequence.
module bullet_hit_receiver #(
   parameter int TARGET_HALF    = 8,
   parameter int BULLET_SIZE    = 3,
   parameter int MAX_HEALTH     = 3,
   parameter int INVULN_FRAMES  = 60,
   parameter int RESPAWN_FRAMES = 120,
   parameter int FLASH_SHIFT    = 3
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [9:0] BulletX,
   input  logic [9:0] BulletY,
   input  logic       bullet_active,
   input  logic [9:0] TargetX,
   input  logic [9:0] TargetY,
   output logic       hit,
   output logic       bullet_kill,
   output logic [2:0] health,
   output logic       dead,
   output logic       flash,
   output logic [7:0] hit_count
);

   // state  | meaning
   // ALIVE  | vulnerable; an overlapping live bullet is accepted as a hit
   // INVULN | recovering after a non-fatal hit; overlaps ignored, sprite blinks
   // DEAD   | health exhausted; waits out the respawn delay
   typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

   localparam logic [10:0] REACH        = 11'(TARGET_HALF + BULLET_SIZE);
   localparam logic [7:0]  INVULN_LAST  = 8'(INVULN_FRAMES - 1);
   localparam logic [7:0]  RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
   localparam logic [2:0]  FULL_HEALTH  = 3'(MAX_HEALTH);

   state_t      state;
   logic [7:0]  cnt;
   logic [7:0]  cnt_inc;
   logic [10:0] dx;
   logic [10:0] dy;
   logic        overlap;
   logic        accept;

   // Distances are widened by one bit so the subtraction can never wrap.
   always_comb begin
      dx = (BulletX >= TargetX) ? ({1'b0, BulletX} - {1'b0, TargetX})
                                : ({1'b0, TargetX} - {1'b0, BulletX});
      dy = (BulletY >= TargetY) ? ({1'b0, BulletY} - {1'b0, TargetY})
                                : ({1'b0, TargetY} - {1'b0, BulletY});
      overlap = bullet_active && (dx <= REACH) && (dy <= REACH);
      accept  = overlap && !bullet_kill && (state == ALIVE);
      cnt_inc = cnt + 8'd1;
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state       <= ALIVE;
         cnt         <= 8'd0;
         hit         <= 1'b0;
         bullet_kill <= 1'b0;
         health      <= FULL_HEALTH;
         dead        <= 1'b0;
         flash       <= 1'b0;
         hit_count   <= 8'd0;
      end else begin
         hit <= accept;
         // The kill handshake runs independently of the state machine.
         if (accept)
            bullet_kill <= 1'b1;
         else if (!bullet_active)
            bullet_kill <= 1'b0;

         case (state)
            ALIVE: begin
               if (accept) begin
                  if (hit_count != 8'hFF)
                     hit_count <= hit_count + 8'd1;
                  cnt   <= 8'd0;
                  flash <= 1'b0;
                  if (health == 3'd1) begin
                     health <= 3'd0;
                     dead   <= 1'b1;
                     state  <= DEAD;
                  end else begin
                     health <= health - 3'd1;
                     state  <= INVULN;
                  end
               end
            end
            INVULN: begin
               if (cnt == INVULN_LAST) begin
                  state <= ALIVE;
                  cnt   <= 8'd0;
                  flash <= 1'b0;
               end else begin
                  // flash tracks the counter bit that will be current next frame
                  cnt   <= cnt_inc;
                  flash <= cnt_inc[FLASH_SHIFT];
               end
            end
            DEAD: begin
               flash <= 1'b0;
               if (cnt == RESPAWN_LAST) begin
                  state  <= ALIVE;
                  cnt    <= 8'd0;
                  health <= FULL_HEALTH;
                  dead   <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: state <= ALIVE;
         endcase
      end
   end

endmodule

// File: tb/tb_bullet_hit_receiver.sv
// Directed self-checking bench for bullet_hit_receiver: hits, hitbox edges,
// invulnerability/flash timing, single-bullet guard, death/respawn and async reset.
module tb_bullet_hit_receiver;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic [9:0] BulletX, BulletY, TargetX, TargetY;
   logic       bullet_active;
   logic       hit, bullet_kill, dead, flash;
   logic [2:0] health;
   logic [7:0] hit_count;

   int tests = 0;
   int fails = 0;

   bullet_hit_receiver dut (
      .frame_clk    (frame_clk),
      .Reset        (Reset),
      .BulletX      (BulletX),
      .BulletY      (BulletY),
      .bullet_active(bullet_active),
      .TargetX      (TargetX),
      .TargetY      (TargetY),
      .hit          (hit),
      .bullet_kill  (bullet_kill),
      .health       (health),
      .dead         (dead),
      .flash        (flash),
      .hit_count    (hit_count)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic h, input logic bk, input logic [2:0] hl,
                          input logic d, input logic f, input logic [7:0] hc);
      chk({tag, ".hit"},         8'(hit),         8'(h));
      chk({tag, ".bullet_kill"}, 8'(bullet_kill), 8'(bk));
      chk({tag, ".health"},      8'(health),      8'(hl));
      chk({tag, ".dead"},        8'(dead),        8'(d));
      chk({tag, ".flash"},       8'(flash),       8'(f));
      chk({tag, ".hit_count"},   8'(hit_count),   8'(hc));
   endtask

   initial begin
      Reset = 1'b1;
      TargetX = 10'd320; TargetY = 10'd240;
      BulletX = 10'd0;   BulletY = 10'd0;
      bullet_active = 1'b0;
      tick(); tick();
      chk_all("reset", 0, 0, 3, 0, 0, 0);
      Reset = 1'b0;
      tick();
      chk_all("idle", 0, 0, 3, 0, 0, 0);

      // Centre hit, then drop the bullet
      BulletX = 10'd320; BulletY = 10'd240; bullet_active = 1'b1;
      tick();
      chk_all("centre", 1, 1, 2, 0, 0, 1);
      bullet_active = 1'b0;
      tick();                                   // INVULN counter = 1
      chk_all("drop", 0, 0, 2, 0, 0, 1);

      // Overlapping live bullet throughout INVULN: ignored, flash = cnt[3]
      bullet_active = 1'b1;
      for (int k = 2; k <= 59; k++) begin
         tick();
         chk("inv.hit",   8'(hit),         8'd0);
         chk("inv.kill",  8'(bullet_kill), 8'd0);
         chk("inv.flash", 8'(flash),       8'((k >> 3) & 1));
      end
      tick();                                   // frame 60: back to ALIVE
      chk_all("inv_end", 0, 0, 2, 0, 0, 1);
      tick();
      chk_all("rehit", 1, 1, 1, 0, 0, 2);

      // Single-bullet guard: bullet stays active across INVULN expiry
      for (int k = 1; k <= 64; k++) tick();
      chk_all("guard", 0, 1, 1, 0, 0, 2);
      bullet_active = 1'b0;
      tick();
      chk_all("guard_drop", 0, 0, 1, 0, 0, 2);

      // Fatal hit, kill clears while DEAD
      bullet_active = 1'b1;
      tick();
      chk_all("fatal", 1, 1, 0, 1, 0, 3);
      bullet_active = 1'b0;
      tick();                                   // DEAD counter = 1
      chk_all("dead_drop", 0, 0, 0, 1, 0, 3);
      bullet_active = 1'b1;
      for (int k = 2; k <= 119; k++) begin
         tick();
         chk("dead.dead", 8'(dead),        8'd1);
         chk("dead.hit",  8'(hit),         8'd0);
         chk("dead.kill", 8'(bullet_kill), 8'd0);
      end
      bullet_active = 1'b0;
      tick();                                   // frame 120: respawn
      chk_all("respawn", 0, 0, 3, 0, 0, 3);

      // Hitbox edges in X
      BulletY = 10'd240; bullet_active = 1'b1;
      BulletX = 10'd332; tick();
      chk("edge_x332", 8'(hit), 8'd0);
      BulletX = 10'd308; tick();
      chk("edge_x308", 8'(hit), 8'd0);
      BulletX = 10'd331; tick();
      chk_all("edge_x331", 1, 1, 2, 0, 0, 4);
      bullet_active = 1'b0;
      for (int k = 1; k <= 60; k++) tick();
      chk_all("x_recover", 0, 0, 2, 0, 0, 4);

      // Hitbox edges in Y
      BulletX = 10'd320; bullet_active = 1'b1;
      BulletY = 10'd252; tick();
      chk("edge_y252", 8'(hit), 8'd0);
      BulletY = 10'd229; tick();
      chk_all("edge_y229", 1, 1, 1, 0, 0, 5);
      bullet_active = 1'b0;
      for (int k = 1; k <= 60; k++) tick();
      BulletY = 10'd251; bullet_active = 1'b1;
      tick();
      chk_all("edge_y251", 1, 1, 0, 1, 0, 6);

      // Async reset mid-DEAD with a pending kill, no clock edge
      tick(); tick();
      chk_all("pre_reset", 0, 1, 0, 1, 0, 6);
      #2 Reset = 1'b1;
      #1;
      chk_all("async_reset", 0, 0, 3, 0, 0, 0);
      #1 Reset = 1'b0;
      bullet_active = 1'b0;
      tick();
      chk_all("post_reset", 0, 0, 3, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
